// File: rtl/laser_cover_search.sv
// Two-disc coverage search: loads a frame of points, then greedily places
// two radius-R discs and refines them alternately to maximise covered points.
module laser_cover_search #(
    parameter int COORD_W = 4,
    parameter int N_PTS   = 40,
    parameter int R       = 4,
    parameter int ITER    = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic [COORD_W-1:0]             X,
    input  logic [COORD_W-1:0]             Y,
    output logic [COORD_W-1:0]             C1X,
    output logic [COORD_W-1:0]             C1Y,
    output logic [COORD_W-1:0]             C2X,
    output logic [COORD_W-1:0]             C2Y,
    output logic [$clog2(N_PTS+1)-1:0]     COVER,
    output logic                           DONE
);

    localparam int CW = $clog2(N_PTS + 1);
    localparam int IW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
    localparam int SW = 2 * COORD_W + 1;
    localparam int KW = $clog2(ITER + 2);
    localparam logic [SW-1:0] RR = SW'(R * R);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_PTS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SCAN1 = 3'd2;
    localparam logic [2:0] S_SCAN2 = 3'd3;
    localparam logic [2:0] S_REF1  = 3'd4;
    localparam logic [2:0] S_REF2  = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    logic [2:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic [2*COORD_W-1:0] r_ctr;
    logic [COORD_W-1:0]   r_px [N_PTS];
    logic [COORD_W-1:0]   r_py [N_PTS];
    logic [N_PTS-1:0]     r_mask;
    logic [CW-1:0]        r_gain;
    logic [COORD_W-1:0]   r_bx;
    logic [COORD_W-1:0]   r_by;
    logic [N_PTS-1:0]     r_bmask;
    logic [CW-1:0]        r_bgain;
    logic [COORD_W-1:0]   r_c1x;
    logic [COORD_W-1:0]   r_c1y;
    logic [N_PTS-1:0]     r_c1m;
    logic [COORD_W-1:0]   r_c2x;
    logic [COORD_W-1:0]   r_c2y;
    logic [N_PTS-1:0]     r_c2m;
    logic [KW-1:0]        r_k;
    logic                 r_grew;
    logic [COORD_W-1:0]   r_o_c1x;
    logic [COORD_W-1:0]   r_o_c1y;
    logic [COORD_W-1:0]   r_o_c2x;
    logic [COORD_W-1:0]   r_o_c2y;
    logic [CW-1:0]        r_o_cover;
    logic                 r_done;

    logic [COORD_W-1:0]   w_cx;
    logic [COORD_W-1:0]   w_cy;
    logic [COORD_W-1:0]   w_px;
    logic [COORD_W-1:0]   w_py;
    logic [COORD_W-1:0]   w_dx;
    logic [COORD_W-1:0]   w_dy;
    logic [SW-1:0]        w_d2;
    logic                 w_in;
    logic [N_PTS-1:0]     w_other;
    logic [N_PTS-1:0]     w_bit;
    logic                 w_hit;
    logic                 w_first_pt;
    logic                 w_last_pt;
    logic                 w_phase_end;
    logic                 w_scan;
    logic                 w_ref;
    logic [N_PTS-1:0]     w_mask_n;
    logic [CW-1:0]        w_gain_n;
    logic                 w_take;
    logic [COORD_W-1:0]   w_fin_x;
    logic [COORD_W-1:0]   w_fin_y;
    logic [N_PTS-1:0]     w_fin_m;
    logic                 w_grew_n;
    logic [KW-1:0]        w_k_n;

    function automatic logic [CW-1:0] f_pop(input logic [N_PTS-1:0] m);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_PTS; i++) begin
            c = c + CW'(m[i]);
        end
        return c;
    endfunction

    assign IN_READY = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign C1X      = r_o_c1x;
    assign C1Y      = r_o_c1y;
    assign C2X      = r_o_c2x;
    assign C2Y      = r_o_c2y;
    assign COVER    = r_o_cover;
    assign DONE     = r_done;

    // Distance test of the current point against the current candidate centre
    assign w_cx   = r_ctr[COORD_W-1:0];
    assign w_cy   = r_ctr[2*COORD_W-1:COORD_W];
    assign w_px   = r_px[r_idx];
    assign w_py   = r_py[r_idx];
    assign w_dx   = (w_cx >= w_px) ? (w_cx - w_px) : (w_px - w_cx);
    assign w_dy   = (w_cy >= w_py) ? (w_cy - w_py) : (w_py - w_cy);
    assign w_d2   = SW'(w_dx) * SW'(w_dx) + SW'(w_dy) * SW'(w_dy);
    assign w_in   = (w_d2 <= RR);
    assign w_bit  = N_PTS'(1) << r_idx;

    // Points already owned by the other (fixed) disc earn no gain
    always_comb begin
        w_other = '0;
        case (r_state)
            S_SCAN2, S_REF2: w_other = r_c1m;
            S_REF1:          w_other = r_c2m;
            default:         w_other = '0;
        endcase
    end

    assign w_hit       = w_in & ~w_other[r_idx];
    assign w_first_pt  = (r_idx == '0);
    assign w_last_pt   = (r_idx == IDX_LAST);
    assign w_phase_end = w_last_pt && (&r_ctr);
    assign w_scan      = (r_state == S_SCAN1) || (r_state == S_SCAN2);
    assign w_ref       = (r_state == S_REF1) || (r_state == S_REF2);
    assign w_mask_n    = (w_first_pt ? '0 : r_mask) | (w_in ? w_bit : '0);
    assign w_gain_n    = (w_first_pt ? '0 : r_gain) + CW'(w_hit);
    // Greedy phases always take the first centre; later ones need strict gain
    assign w_take      = w_last_pt &&
                         ((w_gain_n > r_bgain) || (w_scan && (r_ctr == '0)));
    assign w_fin_x     = w_take ? w_cx : r_bx;
    assign w_fin_y     = w_take ? w_cy : r_by;
    assign w_fin_m     = w_take ? w_mask_n : r_bmask;
    assign w_grew_n    = r_grew | (w_ref & w_take);
    assign w_k_n       = r_k + 1'b1;

    // Point store, written in arrival order while loading
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_PTS; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else if (IN_READY && IN_VALID) begin
            r_px[r_idx] <= X;
            r_py[r_idx] <= Y;
        end
    end

    // Sequencer: load, raster scans with best tracking, refinement, report
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_ctr     <= '0;
            r_mask    <= '0;
            r_gain    <= '0;
            r_bx      <= '0;
            r_by      <= '0;
            r_bmask   <= '0;
            r_bgain   <= '0;
            r_c1x     <= '0;
            r_c1y     <= '0;
            r_c1m     <= '0;
            r_c2x     <= '0;
            r_c2y     <= '0;
            r_c2m     <= '0;
            r_k       <= '0;
            r_grew    <= 1'b0;
            r_o_c1x   <= '0;
            r_o_c1y   <= '0;
            r_o_c2x   <= '0;
            r_o_c2y   <= '0;
            r_o_cover <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (IN_VALID) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_SCAN1;
                            r_idx   <= '0;
                            r_ctr   <= '0;
                            r_bx    <= '0;
                            r_by    <= '0;
                            r_bmask <= '0;
                            r_bgain <= '0;
                        end else begin
                            r_state <= S_LOAD;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                S_SCAN1, S_SCAN2, S_REF1, S_REF2: begin
                    r_mask <= w_mask_n;
                    r_gain <= w_gain_n;
                    if (w_last_pt) begin
                        r_idx <= '0;
                        r_ctr <= r_ctr + 1'b1;
                        if (w_take) begin
                            r_bx    <= w_cx;
                            r_by    <= w_cy;
                            r_bmask <= w_mask_n;
                            r_bgain <= w_gain_n;
                        end
                        r_grew <= w_grew_n;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                    if (w_phase_end) begin
                        case (r_state)
                            S_SCAN1: begin
                                r_c1x   <= w_fin_x;
                                r_c1y   <= w_fin_y;
                                r_c1m   <= w_fin_m;
                                r_bx    <= '0;
                                r_by    <= '0;
                                r_bmask <= '0;
                                r_bgain <= '0;
                                r_state <= S_SCAN2;
                            end
                            S_SCAN2: begin
                                r_c2x <= w_fin_x;
                                r_c2y <= w_fin_y;
                                r_c2m <= w_fin_m;
                                if (ITER == 0) begin
                                    r_state <= S_OUT;
                                end else begin
                                    r_bx    <= r_c1x;
                                    r_by    <= r_c1y;
                                    r_bmask <= r_c1m;
                                    r_bgain <= f_pop(r_c1m & ~w_fin_m);
                                    r_k     <= '0;
                                    r_grew  <= 1'b0;
                                    r_state <= S_REF1;
                                end
                            end
                            S_REF1: begin
                                r_c1x   <= w_fin_x;
                                r_c1y   <= w_fin_y;
                                r_c1m   <= w_fin_m;
                                r_bx    <= r_c2x;
                                r_by    <= r_c2y;
                                r_bmask <= r_c2m;
                                r_bgain <= f_pop(r_c2m & ~w_fin_m);
                                r_state <= S_REF2;
                            end
                            S_REF2: begin
                                r_c2x <= w_fin_x;
                                r_c2y <= w_fin_y;
                                r_c2m <= w_fin_m;
                                r_k   <= w_k_n;
                                if (!w_grew_n || (w_k_n == KW'(ITER))) begin
                                    r_state <= S_OUT;
                                end else begin
                                    r_bx    <= r_c1x;
                                    r_by    <= r_c1y;
                                    r_bmask <= r_c1m;
                                    r_bgain <= f_pop(r_c1m & ~w_fin_m);
                                    r_grew  <= 1'b0;
                                    r_state <= S_REF1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_OUT: begin
                    r_o_c1x   <= r_c1x;
                    r_o_c1y   <= r_c1y;
                    r_o_c2x   <= r_c2x;
                    r_o_c2y   <= r_c2y;
                    r_o_cover <= f_pop(r_c1m | r_c2m);
                    r_done    <= 1'b1;
                    r_idx     <= '0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_cover_search.sv
// Bench for laser_cover_search: a refining build and a greedy-only build
// share one point stream and are compared against a set-based model.
module tb_laser_cover_search;

    localparam int CW  = 3;
    localparam int NP  = 12;
    localparam int RAD = 2;
    localparam int IT  = 2;
    localparam int G   = 1 << CW;
    localparam int P   = G * G * NP;
    localparam int KW  = $clog2(NP + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic [CW-1:0] X = '0;
    logic [CW-1:0] Y = '0;

    logic          rdy_a, done_a, rdy_b, done_b;
    logic [CW-1:0] c1x_a, c1y_a, c2x_a, c2y_a;
    logic [CW-1:0] c1x_b, c1y_b, c2x_b, c2y_b;
    logic [KW-1:0] cov_a, cov_b;

    int checks = 0;
    int errors = 0;
    int px[NP];
    int py[NP];
    int oa[5];
    int ob[5];

    laser_cover_search #(.COORD_W(CW), .N_PTS(NP), .R(RAD), .ITER(IT)) u_dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy_a),
        .X(X), .Y(Y), .C1X(c1x_a), .C1Y(c1y_a), .C2X(c2x_a), .C2Y(c2y_a),
        .COVER(cov_a), .DONE(done_a)
    );

    laser_cover_search #(.COORD_W(CW), .N_PTS(NP), .R(RAD), .ITER(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy_b),
        .X(X), .Y(Y), .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b),
        .COVER(cov_b), .DONE(done_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Set of points inside the disc centred at (cx,cy)
    function automatic bit [NP-1:0] disc(input int cx, input int cy);
        bit [NP-1:0] s;
        s = '0;
        for (int i = 0; i < NP; i++) begin
            if ((cx - px[i]) * (cx - px[i]) + (cy - py[i]) * (cy - py[i]) <= RAD * RAD)
                s[i] = 1'b1;
        end
        return s;
    endfunction

    // Earliest raster centre whose new-point count beats seed; else keep (bx,by)
    task automatic best(input bit [NP-1:0] excl, input int seed,
                        inout int bx, inout int by);
        int bg;
        int g;
        bg = seed;
        for (int y = 0; y < G; y++) begin
            for (int x = 0; x < G; x++) begin
                g = $countones(disc(x, y) & ~excl);
                if (g > bg) begin
                    bg = g;
                    bx = x;
                    by = y;
                end
            end
        end
    endtask

    task automatic model(input int iter, output int r[5], output int k);
        int a1x, a1y, a2x, a2y, u0;
        bit [NP-1:0] d1, d2;
        a1x = 0; a1y = 0; a2x = 0; a2y = 0; k = 0;
        best('0, -1, a1x, a1y);
        best(disc(a1x, a1y), -1, a2x, a2y);
        for (int p = 0; p < iter; p++) begin
            d1 = disc(a1x, a1y);
            d2 = disc(a2x, a2y);
            u0 = $countones(d1 | d2);
            k++;
            best(d2, $countones(d1 & ~d2), a1x, a1y);
            d1 = disc(a1x, a1y);
            best(d1, $countones(d2 & ~d1), a2x, a2y);
            d2 = disc(a2x, a2y);
            if ($countones(d1 | d2) == u0) break;
        end
        r[0] = a1x; r[1] = a1y; r[2] = a2x; r[3] = a2y;
        r[4] = $countones(disc(a1x, a1y) | disc(a2x, a2y));
    endtask

    // Streams px/py into both engines; returns at the negedge before the last accept edge
    task automatic load(input bit gaps);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < NP && cyc < 4 * NP) begin
            @(negedge CLK);
            if (gaps && (cyc % 2 == 1)) begin
                IN_VALID = 1'b0;
            end else begin
                IN_VALID = 1'b1;
                X = CW'(px[i]);
                Y = CW'(py[i]);
            end
            if (IN_VALID && rdy_a) i++;
            cyc++;
        end
        chk("load_count", i, NP);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_c1x"}, int'(c1x_a), 0);
        chk({tag, "_c2y"}, int'(c2y_a), 0);
        chk({tag, "_cov"}, int'(cov_a), 0);
        chk({tag, "_done"}, int'(done_a), 0);
        chk({tag, "_rdy"}, int'(rdy_a), 1);
        chk({tag, "_rdy0"}, int'(rdy_b), 1);
        chk({tag, "_cov0"}, int'(cov_b), 0);
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        int ea[5];
        int eb[5];
        int ka, kb, n, na, nb, cnt_a, cnt_b, rdy_hi, budget;
        model(IT, ea, ka);
        model(0, eb, kb);
        load(gaps);
        n = 0; na = 0; nb = 0; cnt_a = 0; cnt_b = 0; rdy_hi = 0;
        budget = (2 + 2 * IT) * P + 20;
        // n = cycle index after the cycle in which the last point was accepted
        while (n < budget) begin
            @(negedge CLK);
            n++;
            if (n == 1) IN_VALID = 1'b0;
            if (done_b) begin
                cnt_b++;
                if (nb == 0) begin
                    nb = n;
                    ob = '{int'(c1x_b), int'(c1y_b), int'(c2x_b), int'(c2y_b), int'(cov_b)};
                end
            end
            if (done_a) begin
                cnt_a++;
                if (na == 0) begin
                    na = n;
                    oa = '{int'(c1x_a), int'(c1y_a), int'(c2x_a), int'(c2y_a), int'(cov_a)};
                end
            end
            if (na == 0 && rdy_a) rdy_hi++;
            if (na != 0 && n > na + 1) break;
        end
        chk({tag, "_lat_greedy"}, nb, 2 * P + 2);
        chk({tag, "_lat_ref"}, na, (2 + 2 * ka) * P + 2);
        chk({tag, "_done_width"}, cnt_a, 1);
        chk({tag, "_done_width0"}, cnt_b, 1);
        chk({tag, "_ready_busy"}, rdy_hi, 0);
        chk({tag, "_c1x"}, oa[0], ea[0]);
        chk({tag, "_c1y"}, oa[1], ea[1]);
        chk({tag, "_c2x"}, oa[2], ea[2]);
        chk({tag, "_c2y"}, oa[3], ea[3]);
        chk({tag, "_cover"}, oa[4], ea[4]);
        chk({tag, "_g_c1x"}, ob[0], eb[0]);
        chk({tag, "_g_c1y"}, ob[1], eb[1]);
        chk({tag, "_g_c2x"}, ob[2], eb[2]);
        chk({tag, "_g_c2y"}, ob[3], eb[3]);
        chk({tag, "_g_cover"}, ob[4], eb[4]);
    endtask

    task automatic set_t1();
        for (int i = 0; i < NP; i++) begin
            px[i] = 3; py[i] = 3;
        end
    endtask

    task automatic set_t2();
        for (int i = 0; i < NP; i++) begin
            px[i] = (i < NP / 2) ? 1 : 6;
            py[i] = (i < NP / 2) ? 1 : 6;
        end
    endtask

    task automatic set_rand();
        int cx[3];
        int cy[3];
        int v;
        for (int c = 0; c < 3; c++) begin
            cx[c] = $urandom_range(0, G - 1);
            cy[c] = $urandom_range(0, G - 1);
        end
        for (int i = 0; i < NP; i++) begin
            v = cx[i % 3] + $urandom_range(0, 4) - 2;
            px[i] = (v < 0) ? 0 : (v > G - 1) ? G - 1 : v;
            v = cy[i % 3] + $urandom_range(0, 4) - 2;
            py[i] = (v < 0) ? 0 : (v > G - 1) ? G - 1 : v;
        end
    endtask

    initial begin
        RST = 1'b1;
        @(negedge CLK);
        check_reset("reset");
        @(negedge CLK);
        RST = 1'b0;

        set_t1();
        run_frame("t1", 1'b0);
        chk("t1_c1x_const", oa[0], 3);
        chk("t1_c1y_const", oa[1], 1);
        chk("t1_cover_const", oa[4], NP);

        set_t2();
        run_frame("t2", 1'b0);
        chk("t2_c1_const", oa[0] + 10 * oa[1], 0);
        chk("t2_c2x_const", oa[2], 6);
        chk("t2_c2y_const", oa[3], 4);
        chk("t2_cover_const", oa[4], NP);

        for (int i = 0; i < NP; i++) begin
            px[i] = (i == NP - 1) ? RAD : 0;
            py[i] = 0;
        end
        run_frame("t3", 1'b0);
        chk("t3_c1x_const", oa[0], 0);
        chk("t3_c1y_const", oa[1], 0);
        chk("t3_cover_const", oa[4], NP);

        set_t2();
        run_frame("t4", 1'b1);

        set_t1();
        load(1'b0);
        repeat (50) begin
            @(negedge CLK);
            IN_VALID = 1'b0;
        end
        chk("t5_busy", int'(rdy_a), 0);
        RST = 1'b1;
        #1;
        check_reset("t5_rst");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        run_frame("t5", 1'b0);

        for (int f = 0; f < 4; f++) begin
            set_rand();
            run_frame($sformatf("rnd%0d", f), f[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
